// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch (T0-T2), opcode decode, then execute steps
// for load/store/ALU/output instructions. Strobes are Moore outputs of state and IR.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        BAout,
    output logic        Rout,
    output logic        Cout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Rin,
    output logic        CONin,
    output logic        OutportIn,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  ALU_Control,
    output logic        Run
);

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD   = 5'd2;
    localparam logic [4:0] ALU_SUB   = 5'd3;
    localparam logic [4:0] ALU_AND   = 5'd4;
    localparam logic [4:0] ALU_OR    = 5'd5;
    localparam logic [4:0] ALU_INCPC = 5'd12;

    state_t     state_q;
    state_t     last_state;
    logic [4:0] opcode;
    logic [4:0] alu_code;
    logic       is_ld, is_ldi, is_st, is_alu_reg, is_alu_imm, is_out, is_halt;
    logic       is_addr;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    assign is_ld      = (opcode == OP_LD);
    assign is_ldi     = (opcode == OP_LDI);
    assign is_st      = (opcode == OP_ST);
    assign is_alu_reg = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                        (opcode == OP_AND) || (opcode == OP_OR);
    assign is_alu_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI) ||
                        (opcode == OP_ORI);
    assign is_out     = (opcode == OP_OUT);
    assign is_halt    = (opcode == OP_HALT);
    assign is_addr    = is_ld || is_ldi || is_st;

    always_comb begin
        alu_code = ALU_ADD;
        case (opcode)
            OP_SUB:           alu_code = ALU_SUB;
            OP_AND, OP_ANDI:  alu_code = ALU_AND;
            OP_OR,  OP_ORI:   alu_code = ALU_OR;
            default:          alu_code = ALU_ADD;
        endcase
    end

    // Final step of the current opcode; nop and undefined opcodes end after fetch.
    always_comb begin
        last_state = S_T2;
        if (is_ld || is_st)
            last_state = S_T7;
        else if (is_ldi || is_alu_reg || is_alu_imm)
            last_state = S_T5;
        else if (is_out || is_halt)
            last_state = S_T3;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_RST;
        end else begin
            case (state_q)
                S_RST:   state_q <= Stop ? S_HALT : S_T0;
                S_HALT:  state_q <= S_HALT;
                default: begin
                    if (state_q == S_T3 && is_halt)
                        state_q <= S_HALT;
                    else if (state_q == last_state)
                        state_q <= Stop ? S_HALT : S_T0;
                    else
                        state_q <= state_t'(state_q + 4'd1);
                end
            endcase
        end
    end

    always_comb begin
        PCout       = 1'b0;
        Zlowout     = 1'b0;
        MDRout      = 1'b0;
        BAout       = 1'b0;
        Rout        = 1'b0;
        Cout        = 1'b0;
        PCin        = 1'b0;
        MARin       = 1'b0;
        MDRin       = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Zin         = 1'b0;
        Rin         = 1'b0;
        CONin       = 1'b0;
        OutportIn   = 1'b0;
        Gra         = 1'b0;
        Grb         = 1'b0;
        Grc         = 1'b0;
        Read        = 1'b0;
        Write       = 1'b0;
        ALU_Control = 5'd0;
        Run         = (state_q != S_HALT);

        case (state_q)
            S_T0: begin
                PCout       = 1'b1;
                MARin       = 1'b1;
                Zin         = 1'b1;
                ALU_Control = ALU_INCPC;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (is_addr) begin
                    Grb   = 1'b1;
                    BAout = 1'b1;
                    Yin   = 1'b1;
                end else if (is_alu_reg || is_alu_imm) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (is_out) begin
                    Gra       = 1'b1;
                    Rout      = 1'b1;
                    OutportIn = 1'b1;
                end
            end
            S_T4: begin
                Zin = 1'b1;
                if (is_addr) begin
                    Cout        = 1'b1;
                    ALU_Control = ALU_ADD;
                end else if (is_alu_reg) begin
                    Grc         = 1'b1;
                    Rout        = 1'b1;
                    ALU_Control = alu_code;
                end else begin
                    Cout        = 1'b1;
                    ALU_Control = alu_code;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_ld || is_st) begin
                    MARin = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end
            S_T6: begin
                MDRin = 1'b1;
                if (is_ld) begin
                    Read = 1'b1;
                end else begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
